// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM state type and digit helpers for the binary-to-BCD converter
package bcd_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FIN
    } state_t;

    function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] digit);
        return (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;
    endfunction

    // Callers zero-extend their packed digits to MAX_DIGITS and truncate the result to their width.
    function automatic logic [MAX_DIGITS-1:0] blank_mask(
        input logic [DIGIT_W*MAX_DIGITS-1:0] bcd,
        input int                            digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < digits) begin
                zero_above = zero_above & (bcd[DIGIT_W*i +: DIGIT_W] == '0);
                mask[i]    = zero_above;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit of the shift-add-3 chain with carry-style shift in/out
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               shift_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               shift_out
);

    logic [DIGIT_W-1:0] corrected;

    assign corrected = add3(digit);
    assign shift_out = corrected[DIGIT_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (shift_en) begin
            digit <= {corrected[DIGIT_W-2:0], shift_in};
        end
    end

endmodule

// File: rtl/bcd_conv_seq.sv
// rtl/bcd_conv_seq.sv - sequential binary-to-BCD converter, one operand bit per clock
module bcd_conv_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      neg,
    output logic                      ovf,
    output logic [DIGITS-1:0]         blank
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t                      state, state_next;
    logic                        accept, load_en, shift_en, fin_en, last_bit;
    logic [CNT_W-1:0]            cnt;
    logic [BIN_W-1:0]            mag, bin_mag;
    logic                        bin_neg, neg_lat, ovf_sticky;
    logic [DIGIT_W*DIGITS-1:0]   work;
    logic [DIGITS:0]             chain;
    logic [DIGIT_W*MAX_DIGITS-1:0] work_ext;

    assign bin_neg  = SIGNED && bin[BIN_W-1];
    assign bin_mag  = bin_neg ? -bin : bin;
    assign last_bit = (cnt == CNT_W'(BIN_W - 1));
    assign chain[0] = mag[BIN_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        accept     = 1'b0;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        fin_en     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                fin_en     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (load_en),
            .shift_en  (shift_en),
            .shift_in  (chain[g]),
            .digit     (work[DIGIT_W*g +: DIGIT_W]),
            .shift_out (chain[g+1])
        );
    end

    always_comb begin
        work_ext                       = '0;
        work_ext[DIGIT_W*DIGITS-1:0]   = work;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag        <= '0;
            neg_lat    <= 1'b0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
            blank      <= '0;
        end else begin
            done <= fin_en;
            if (accept) begin
                mag     <= bin_mag;
                neg_lat <= bin_neg;
            end
            if (load_en) begin
                cnt        <= '0;
                ovf_sticky <= 1'b0;
            end
            if (shift_en) begin
                mag        <= mag << 1;
                cnt        <= cnt + 1'b1;
                ovf_sticky <= ovf_sticky | chain[DIGITS];
            end
            if (fin_en) begin
                ovf <= ovf_sticky;
                // A zero magnitude leaves every digit clear with no overflow, so it never reports negative.
                neg <= neg_lat && (ovf_sticky || (work != '0));
                if (ovf_sticky) begin
                    bcd   <= {DIGITS{4'h9}};
                    blank <= '0;
                end else begin
                    bcd   <= work;
                    blank <= DIGITS'(blank_mask(work_ext, DIGITS));
                end
            end
        end
    end

endmodule
